usb_bulk_ep_router: RTL and testbench

Parametrised N-endpoint bulk router between the USB `protocol` core's single bulk data path and per-endpoint AXI4-Stream ports. It generalises the fixed EP1/EP2 wiring of the ULPI top level to `NUM_EP` endpoints. It adds:
- IN multiplexing and OUT demultiplexing, keyed on the endpoint number latched at transfer start;
- per-endpoint ready reporting;
- max-packet enforcement;
- rejection of invalid endpoints.

It sits in the USB clock domain, between `protocol` (`blk_*` ports) and user endpoint logic.

---
 rtl/usb_bulk_ep_router_pkg.sv | 18 +
 rtl/usb_bulk_ep_router_skid.sv | 55 +++++
 rtl/usb_bulk_ep_router.sv | 159 +++++++++++++++
 tb/tb_usb_bulk_ep_router.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bulk_ep_router_pkg.sv
// Shared definitions for the bulk endpoint router: state encoding, endpoint limits.
package usb_bulk_ep_router_pkg;

  localparam int unsigned UsbEpMax = 15;
  localparam int unsigned EpW      = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StFlush = 2'd2
  } state_e;

  // True when ep names one of the first num_ep bulk endpoints (endpoint 0 is control).
  function automatic logic ep_in_range(input logic [EpW-1:0] ep, input int unsigned num_ep);
    return (ep != '0) && (32'(ep) <= num_ep) && (32'(ep) <= UsbEpMax);
  endfunction

endpackage

// File: rtl/usb_bulk_ep_router_skid.sv
// AXI4-Stream skid buffer with registered outputs; BYPASS turns it into a plain wire.
module usb_bulk_ep_router_skid #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             flush_i,
  input  logic             s_tvalid_i,
  input  logic             s_tlast_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  output logic             s_tready_o,
  output logic             m_tvalid_o,
  output logic             m_tlast_o,
  output logic [WIDTH-1:0] m_tdata_o,
  input  logic             m_tready_i
);

  logic           out_valid_q, skid_valid_q;
  logic [WIDTH:0] out_q, skid_q;
  logic           out_take;

  assign out_take = m_tready_i || !out_valid_q;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_take) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_q       <= {s_tlast_i, s_tdata_i};
        out_valid_q <= s_tvalid_i;
      end
    end else if (s_tvalid_i && !skid_valid_q) begin
      // Output stalled: park the beat so upstream ready never depends on m_tready_i.
      skid_q       <= {s_tlast_i, s_tdata_i};
      skid_valid_q <= 1'b1;
    end
  end

  assign s_tready_o = BYPASS ? m_tready_i : !skid_valid_q;
  assign m_tvalid_o = BYPASS ? s_tvalid_i : out_valid_q;
  assign m_tlast_o  = BYPASS ? s_tlast_i  : out_q[WIDTH];
  assign m_tdata_o  = BYPASS ? s_tdata_i  : out_q[WIDTH-1:0];

endmodule

// File: rtl/usb_bulk_ep_router.sv
// Routes the protocol core's single bulk data path to NUM_EP per-endpoint AXI4-Stream ports.
module usb_bulk_ep_router
  import usb_bulk_ep_router_pkg::*;
#(
  parameter int unsigned NUM_EP     = 2,
  parameter int unsigned MAX_PACKET = 512,
  parameter bit          PIPELINED  = 1'b0
) (
  input  logic                  clock,
  input  logic                  areset_n,
  input  logic                  blk_start_i,
  input  logic                  blk_cycle_i,
  input  logic [EpW-1:0]        blk_endpt_i,
  output logic                  blk_in_ready_o,
  output logic                  blk_out_ready_o,
  output logic                  blk_error_o,
  input  logic [NUM_EP-1:0]     ep_in_ready_i,
  input  logic [NUM_EP-1:0]     ep_out_ready_i,
  input  logic [NUM_EP-1:0]     s_tvalid_i,
  input  logic [NUM_EP-1:0]     s_tlast_i,
  output logic [NUM_EP-1:0]     s_tready_o,
  input  logic [NUM_EP*8-1:0]   s_tdata_i,
  output logic                  usb_tvalid_o,
  output logic                  usb_tlast_o,
  input  logic                  usb_tready_i,
  output logic [7:0]            usb_tdata_o,
  input  logic                  usb_tvalid_i,
  input  logic                  usb_tlast_i,
  output logic                  usb_tready_o,
  input  logic [7:0]            usb_tdata_i,
  output logic [NUM_EP-1:0]     m_tvalid_o,
  output logic [NUM_EP-1:0]     m_tlast_o,
  input  logic [NUM_EP-1:0]     m_tready_i,
  output logic [NUM_EP*8-1:0]   m_tdata_o
);

  localparam int unsigned CntW = $clog2(MAX_PACKET);

  state_e          state_q, state_d;
  logic [EpW-1:0]  sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_done_q, in_done_d;
  logic            error_q, error_d;
  logic            skid_flush;

  logic [NUM_EP-1:0] hit_ep, hit_sel;
  logic              xfer, src_valid, src_last, in_valid, in_last, skid_ready;
  logic              src_hs, usb_hs_last, out_hs_last;
  logic [7:0]        src_data;

  assign xfer = (state_q == StXfer);

  for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
    logic route;
    assign hit_ep[i]           = (blk_endpt_i == EpW'(i + 1));
    assign hit_sel[i]          = (sel_q == EpW'(i));
    assign route               = xfer && hit_sel[i];
    assign s_tready_o[i]       = route && !in_done_q && skid_ready;
    assign m_tvalid_o[i]       = route && usb_tvalid_i;
    assign m_tlast_o[i]        = route && usb_tlast_i;
    assign m_tdata_o[i*8 +: 8] = route ? usb_tdata_i : 8'h00;
  end

  always_comb begin
    src_data = 8'h00;
    for (int i = 0; i < NUM_EP; i++) begin
      if (hit_sel[i]) src_data = s_tdata_i[i*8 +: 8];
    end
  end

  assign blk_in_ready_o  = |(hit_ep & ep_in_ready_i);
  assign blk_out_ready_o = |(hit_ep & ep_out_ready_i);
  assign blk_error_o     = error_q;

  assign src_valid = |(hit_sel & s_tvalid_i);
  assign src_last  = |(hit_sel & s_tlast_i);
  // in_done_q holds off the source once its final beat has entered the skid buffer.
  assign in_valid  = xfer && !in_done_q && src_valid;
  assign in_last   = xfer && (src_last || (cnt_q == CntW'(MAX_PACKET - 1)));
  assign src_hs    = in_valid && skid_ready;

  assign usb_tready_o = xfer ? |(hit_sel & m_tready_i) : (state_q == StFlush);
  assign usb_hs_last  = usb_tvalid_o && usb_tready_i && usb_tlast_o;
  assign out_hs_last  = usb_tvalid_i && usb_tready_o && usb_tlast_i;

  usb_bulk_ep_router_skid #(
    .WIDTH  (8),
    .BYPASS (!PIPELINED)
  ) u_axis_skid (
    .clock      (clock),
    .areset_n   (areset_n),
    .flush_i    (skid_flush),
    .s_tvalid_i (in_valid),
    .s_tlast_i  (in_last),
    .s_tdata_i  (xfer ? src_data : 8'h00),
    .s_tready_o (skid_ready),
    .m_tvalid_o (usb_tvalid_o),
    .m_tlast_o  (usb_tlast_o),
    .m_tdata_o  (usb_tdata_o),
    .m_tready_i (usb_tready_i)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    in_done_d  = in_done_q;
    error_d    = 1'b0;
    skid_flush = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (blk_start_i) begin
          if (ep_in_range(blk_endpt_i, NUM_EP)) begin
            sel_d     = blk_endpt_i - EpW'(1);
            cnt_d     = '0;
            in_done_d = 1'b0;
            state_d   = StXfer;
          end else begin
            error_d = 1'b1;
            state_d = StFlush;
          end
        end
      end
      StXfer: begin
        if (src_hs) begin
          cnt_d = in_last ? '0 : cnt_q + CntW'(1);
          if (in_last) in_done_d = 1'b1;
        end
        if (!blk_cycle_i) begin
          state_d    = StIdle;
          skid_flush = 1'b1;
        end else if (usb_hs_last || out_hs_last) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (!blk_cycle_i || (usb_tvalid_i && usb_tlast_i)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      cnt_q     <= '0;
      in_done_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      in_done_q <= in_done_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_usb_bulk_ep_router.sv
// Randomized bench for usb_bulk_ep_router against a packet-level reference model.
module tb_usb_bulk_ep_router;

  localparam int NumEp  = 3;
  localparam int MaxPkt = 8;
  localparam int MemD   = 1024;

  logic                 clock, areset_n;
  logic                 blk_start_i, blk_cycle_i;
  logic [3:0]           blk_endpt_i;
  logic                 blk_in_ready_o, blk_out_ready_o, blk_error_o;
  logic [NumEp-1:0]     ep_in_ready_i, ep_out_ready_i;
  logic [NumEp-1:0]     s_tvalid_i, s_tlast_i, s_tready_o;
  logic [NumEp*8-1:0]   s_tdata_i;
  logic                 usb_tvalid_o, usb_tlast_o, usb_tready_i;
  logic [7:0]           usb_tdata_o;
  logic                 usb_tvalid_i, usb_tlast_i, usb_tready_o;
  logic [7:0]           usb_tdata_i;
  logic [NumEp-1:0]     m_tvalid_o, m_tlast_o, m_tready_i;
  logic [NumEp*8-1:0]   m_tdata_o;

  usb_bulk_ep_router #(
    .NUM_EP     (NumEp),
    .MAX_PACKET (MaxPkt),
    .PIPELINED  (1'b0)
  ) dut (
    .clock           (clock),
    .areset_n        (areset_n),
    .blk_start_i     (blk_start_i),
    .blk_cycle_i     (blk_cycle_i),
    .blk_endpt_i     (blk_endpt_i),
    .blk_in_ready_o  (blk_in_ready_o),
    .blk_out_ready_o (blk_out_ready_o),
    .blk_error_o     (blk_error_o),
    .ep_in_ready_i   (ep_in_ready_i),
    .ep_out_ready_i  (ep_out_ready_i),
    .s_tvalid_i      (s_tvalid_i),
    .s_tlast_i       (s_tlast_i),
    .s_tready_o      (s_tready_o),
    .s_tdata_i       (s_tdata_i),
    .usb_tvalid_o    (usb_tvalid_o),
    .usb_tlast_o     (usb_tlast_o),
    .usb_tready_i    (usb_tready_i),
    .usb_tdata_o     (usb_tdata_o),
    .usb_tvalid_i    (usb_tvalid_i),
    .usb_tlast_i     (usb_tlast_i),
    .usb_tready_o    (usb_tready_o),
    .usb_tdata_i     (usb_tdata_i),
    .m_tvalid_o      (m_tvalid_o),
    .m_tlast_o       (m_tlast_o),
    .m_tready_i      (m_tready_i),
    .m_tdata_o       (m_tdata_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Per-endpoint IN source streams: {last, data}, consumed from hd, appended at tl.
  logic [8:0] src_mem [NumEp][MemD];
  int         src_hd  [NumEp];
  int         src_tl  [NumEp];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic ref_ready(input logic [NumEp-1:0] v, input int ep);
    if (ep < 1 || ep > NumEp) return 1'b0;
    return v[ep-1];
  endfunction

  task automatic drive_src();
    for (int i = 0; i < NumEp; i++) begin
      s_tvalid_i[i]       = (src_hd[i] != src_tl[i]);
      s_tdata_i[i*8 +: 8] = src_mem[i][src_hd[i]][7:0];
      s_tlast_i[i]        = src_mem[i][src_hd[i]][8];
    end
  endtask

  task automatic push_pkt(input int e, input int len);
    for (int k = 0; k < len; k++) begin
      src_mem[e][src_tl[e]] = {(k == len - 1), 8'($urandom)};
      src_tl[e]++;
    end
    drive_src();
  endtask

  task automatic start_xfer(input int ep);
    blk_endpt_i  = 4'(ep);
    blk_start_i  = 1'b1;
    blk_cycle_i  = 1'b1;
    usb_tready_i = 1'b0;
    usb_tvalid_i = 1'b0;
    usb_tlast_i  = 1'b0;
    @(negedge clock);
    check_eq("start_in_rdy", blk_in_ready_o, ref_ready(ep_in_ready_i, ep));
    check_eq("start_out_rdy", blk_out_ready_o, ref_ready(ep_out_ready_i, ep));
    @(posedge clock); #1;
    blk_start_i = 1'b0;
  endtask

  // With data offered on both paths, an idle router must accept and present nothing.
  task automatic idle_check(input string tag);
    blk_start_i  = 1'b0;
    blk_cycle_i  = 1'b0;
    usb_tready_i = 1'b1;
    m_tready_i   = '1;
    usb_tvalid_i = 1'b1;
    usb_tlast_i  = 1'b0;
    @(negedge clock);
    check_eq(tag, {usb_tvalid_o, usb_tready_o, s_tready_o, m_tvalid_o, blk_error_o}, 32'd0);
    @(posedge clock); #1;
    usb_tready_i = 1'b0;
    usb_tvalid_i = 1'b0;
  endtask

  task automatic do_in(input int ep, input int abort_after);
    logic [7:0] exp_d [MaxPkt];
    logic       exp_l [MaxPkt];
    int e, nexp, idx, target, got, cyc;
    logic hs;
    e    = ep - 1;
    nexp = 0;
    idx  = src_hd[e];
    while (nexp < MaxPkt && idx < src_tl[e]) begin
      exp_d[nexp] = src_mem[e][idx][7:0];
      exp_l[nexp] = src_mem[e][idx][8] || (nexp == MaxPkt - 1);
      nexp++;
      if (src_mem[e][idx][8]) break;
      idx++;
    end
    target = (abort_after >= 0 && abort_after < nexp) ? abort_after : nexp;
    ep_in_ready_i  = NumEp'($urandom);
    ep_out_ready_i = NumEp'($urandom);
    start_xfer(ep);
    got = 0;
    cyc = 0;
    while (got < target && cyc < 200) begin
      usb_tready_i = ($urandom_range(3) != 0);
      @(negedge clock);
      check_eq("in_s_tready", s_tready_o, usb_tready_i ? (32'd1 << e) : 32'd0);
      hs = usb_tvalid_o && usb_tready_i;
      if (hs) begin
        check_eq("in_data", usb_tdata_o, exp_d[got]);
        check_eq("in_last", usb_tlast_o, exp_l[got]);
        got++;
      end
      @(posedge clock); #1;
      if (hs) src_hd[e]++;
      drive_src();
      cyc++;
    end
    if (cyc >= 200) check_eq("in_timeout", 32'd0, 32'd1);
    usb_tready_i = 1'b0;
    if (target < nexp) begin
      blk_cycle_i = 1'b0;
      @(posedge clock); #1;
    end
    idle_check("in_idle");
  endtask

  task automatic do_out(input int ep, input int len);
    int e, b, cyc;
    logic hs;
    e              = ep - 1;
    ep_in_ready_i  = NumEp'($urandom);
    ep_out_ready_i = NumEp'($urandom);
    start_xfer(ep);
    b   = 0;
    cyc = 0;
    while (b < len && cyc < 200) begin
      if (!usb_tvalid_i) begin
        usb_tvalid_i = ($urandom_range(3) != 0);
        usb_tdata_i  = 8'($urandom);
        usb_tlast_i  = (b == len - 1);
      end
      m_tready_i = NumEp'($urandom);
      @(negedge clock);
      check_eq("out_m_tvalid", m_tvalid_o, usb_tvalid_i ? (32'd1 << e) : 32'd0);
      check_eq("out_usb_tready", usb_tready_o, m_tready_i[e]);
      hs = usb_tvalid_i && m_tready_i[e];
      if (hs) begin
        check_eq("out_data", m_tdata_o[e*8 +: 8], usb_tdata_i);
        check_eq("out_last", m_tlast_o[e], usb_tlast_i);
      end
      @(posedge clock); #1;
      if (hs) begin
        b++;
        usb_tvalid_i = 1'b0;
        usb_tlast_i  = 1'b0;
      end
      cyc++;
    end
    if (cyc >= 200) check_eq("out_timeout", 32'd0, 32'd1);
    idle_check("out_idle");
  endtask

  task automatic do_bad(input int ep, input int len);
    int b, cyc;
    ep_in_ready_i  = '1;
    ep_out_ready_i = '1;
    start_xfer(ep);
    b   = 0;
    cyc = 0;
    while (b < len && cyc < 200) begin
      if (!usb_tvalid_i) begin
        usb_tvalid_i = ($urandom_range(3) != 0);
        usb_tdata_i  = 8'($urandom);
        usb_tlast_i  = (b == len - 1);
      end
      m_tready_i   = NumEp'($urandom);
      usb_tready_i = 1'b1;
      @(negedge clock);
      check_eq("bad_error", blk_error_o, (cyc == 0));
      check_eq("bad_sink", {usb_tready_o, usb_tvalid_o, m_tvalid_o}, 32'h10);
      @(posedge clock); #1;
      if (usb_tvalid_i) begin
        b++;
        usb_tvalid_i = 1'b0;
        usb_tlast_i  = 1'b0;
      end
      cyc++;
    end
    if (cyc >= 200) check_eq("bad_timeout", 32'd0, 32'd1);
    idle_check("bad_idle");
  endtask

  task automatic lookup_check();
    int v;
    repeat (3) begin
      ep_in_ready_i  = NumEp'($urandom);
      ep_out_ready_i = NumEp'($urandom);
      v              = $urandom_range(15);
      blk_endpt_i    = 4'(v);
      @(negedge clock);
      check_eq("lk_in", blk_in_ready_o, ref_ready(ep_in_ready_i, v));
      check_eq("lk_out", blk_out_ready_o, ref_ready(ep_out_ready_i, v));
      @(posedge clock); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_usb"}, {usb_tvalid_o, usb_tlast_o, usb_tdata_o, usb_tready_o}, 32'd0);
    check_eq({tag, "_s"}, s_tready_o, 32'd0);
    check_eq({tag, "_m"}, {m_tvalid_o, m_tlast_o}, 32'd0);
    check_eq({tag, "_mdata"}, m_tdata_o, 32'd0);
    check_eq({tag, "_blk"}, {blk_in_ready_o, blk_out_ready_o, blk_error_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic hs;
    int   kind, ep, ab, v;
    for (int i = 0; i < NumEp; i++) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
      for (int k = 0; k < MemD; k++) src_mem[i][k] = 9'd0;
    end
    areset_n       = 1'b0;
    blk_start_i    = 1'b0;
    blk_cycle_i    = 1'b0;
    blk_endpt_i    = 4'd0;
    ep_in_ready_i  = '1;
    ep_out_ready_i = '1;
    usb_tready_i   = 1'b1;
    usb_tvalid_i   = 1'b1;
    usb_tlast_i    = 1'b0;
    usb_tdata_i    = 8'h3c;
    m_tready_i     = '1;
    drive_src();
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    areset_n     = 1'b1;
    usb_tvalid_i = 1'b0;
    usb_tready_i = 1'b0;

    // 4-byte IN packet on endpoint 2
    push_pkt(1, 4);
    do_in(2, -1);
    // 3-byte OUT packet on endpoint 1
    do_out(1, 3);
    // 12-byte source on endpoint 1: forced tlast at byte 8, remainder next transfer
    push_pkt(0, 12);
    do_in(1, -1);
    do_in(1, -1);
    check_eq("maxpkt_drained", src_hd[0] == src_tl[0], 32'd1);
    // invalid endpoint sinks a 6-byte OUT packet
    do_bad(5, 6);
    // abort after 2 of 6 bytes, then retry delivers bytes 3..6
    push_pkt(2, 6);
    do_in(3, 2);
    check_eq("abort_src_hold", s_tvalid_i[2] && (src_tl[2] - src_hd[2] == 4), 32'd1);
    do_in(3, -1);

    // asynchronous reset in the middle of an IN transfer
    push_pkt(1, 6);
    ep_in_ready_i  = '0;
    ep_out_ready_i = '0;
    start_xfer(2);
    usb_tready_i = 1'b1;
    m_tready_i   = '1;
    usb_tvalid_i = 1'b1;
    usb_tlast_i  = 1'b0;
    usb_tdata_i  = 8'h5a;
    repeat (2) begin
      @(negedge clock);
      hs = s_tvalid_i[1] && s_tready_o[1];
      @(posedge clock); #1;
      if (hs) src_hd[1]++;
      drive_src();
    end
    check_eq("pre_rst", {usb_tvalid_o, m_tvalid_o}, 32'hA);
    #2 areset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    blk_cycle_i  = 1'b0;
    usb_tvalid_i = 1'b0;
    usb_tready_i = 1'b0;
    @(posedge clock); #1;
    areset_n = 1'b1;
    idle_check("rst_idle");

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(9);
      ep   = $urandom_range(1, NumEp);
      if (kind <= 3) begin
        if (src_hd[ep-1] == src_tl[ep-1]) push_pkt(ep - 1, $urandom_range(1, 12));
        ab = -1;
        if ($urandom_range(3) == 0) ab = $urandom_range(3);
        do_in(ep, ab);
      end else if (kind <= 6) begin
        do_out(ep, $urandom_range(1, 6));
      end else if (kind == 7) begin
        v = $urandom_range(12);
        do_bad((v == 0) ? 0 : v + 3, $urandom_range(1, 6));
      end else begin
        lookup_check();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
